// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and exception codes for the writeback/commit stage
package wb_pkg;

    localparam int WB_DATA_W    = 32;
    localparam int WB_RADDR_W   = 5;
    localparam int WB_CSR_NUM_W = 14;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0b;
    localparam logic [5:0] ECODE_BRK = 6'h0c;
    localparam logic [5:0] ECODE_INE = 6'h0d;
    localparam logic [5:0] ECODE_IPE = 6'h0e;

    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
    localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

    typedef struct packed {
        logic [WB_DATA_W-1:0]  pc;
        logic [3:0]            we;
        logic [WB_RADDR_W-1:0] waddr;
        logic [WB_DATA_W-1:0]  wdata;
    } wb_trace_t;

    typedef struct packed {
        logic [WB_DATA_W-1:0]    pc;
        logic [WB_DATA_W-1:0]    result;
        logic                    gr_we;
        logic [WB_RADDR_W-1:0]   dest;
        logic                    csr_re;
        logic                    csr_we;
        logic [WB_CSR_NUM_W-1:0] csr_num;
        logic [WB_DATA_W-1:0]    csr_wmask;
        logic [WB_DATA_W-1:0]    csr_wvalue;
        logic                    ex;
        logic [5:0]              ecode;
        logic [8:0]              esubcode;
        logic                    ertn;
    } wb_stage_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - retire-trace FIFO with extra-MSB pointers
module wb_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Equal low bits with differing wrap bits means the writer lapped the reader.
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/wb_commit_stage.sv
// rtl/wb_commit_stage.sv - writeback/commit stage; WB_TRACE_FIFO_EN selects the backpressured trace FIFO
module wb_commit_stage
    import wb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int RADDR_W     = 5,
    parameter int CSR_NUM_W   = 14,
    parameter int TRACE_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ms_valid,
    input  logic [DATA_W-1:0]    ms_pc,
    input  logic [DATA_W-1:0]    ms_result,
    input  logic                 ms_gr_we,
    input  logic [RADDR_W-1:0]   ms_dest,
    input  logic                 ms_csr_re,
    input  logic                 ms_csr_we,
    input  logic [CSR_NUM_W-1:0] ms_csr_num,
    input  logic [DATA_W-1:0]    ms_csr_wmask,
    input  logic [DATA_W-1:0]    ms_csr_wvalue,
    input  logic                 ms_ex,
    input  logic [5:0]           ms_ecode,
    input  logic [8:0]           ms_esubcode,
    input  logic                 ms_ertn,
    output logic                 wb_allowin,
    output logic                 rf_we,
    output logic [RADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 csr_re,
    output logic                 csr_we,
    output logic [CSR_NUM_W-1:0] csr_num,
    output logic [DATA_W-1:0]    csr_wmask,
    output logic [DATA_W-1:0]    csr_wvalue,
    input  logic [DATA_W-1:0]    csr_rvalue,
    output logic                 wb_ex,
    output logic                 ertn_flush,
    output logic [5:0]           wb_ecode,
    output logic [8:0]           wb_esubcode,
    output logic [DATA_W-1:0]    wb_pc,
    output logic                 trace_valid,
    input  logic                 trace_ready,
    output logic [DATA_W-1:0]    trace_pc,
    output logic [3:0]           trace_we,
    output logic [RADDR_W-1:0]   trace_waddr,
    output logic [DATA_W-1:0]    trace_wdata
);

    logic                 ws_valid;
    wb_stage_t            ws_q;
    wb_stage_t            ms_entry;
    logic                 ws_ready_go;
    logic                 retire;
    logic                 flush;
    logic                 accept;
    logic                 trace_push;
    logic [WB_DATA_W-1:0] wdata;
    wb_trace_t            trace_entry;
    wb_trace_t            trace_view;

    assign flush      = wb_ex | ertn_flush;
    assign wb_allowin = ~ws_valid | ws_ready_go;
    assign accept     = ms_valid & wb_allowin & ~flush;
    assign retire     = ws_valid & ws_ready_go;

    always_comb begin
        ms_entry            = '0;
        ms_entry.pc         = WB_DATA_W'(ms_pc);
        ms_entry.result     = WB_DATA_W'(ms_result);
        ms_entry.gr_we      = ms_gr_we;
        ms_entry.dest       = WB_RADDR_W'(ms_dest);
        ms_entry.csr_re     = ms_csr_re;
        ms_entry.csr_we     = ms_csr_we;
        ms_entry.csr_num    = WB_CSR_NUM_W'(ms_csr_num);
        ms_entry.csr_wmask  = WB_DATA_W'(ms_csr_wmask);
        ms_entry.csr_wvalue = WB_DATA_W'(ms_csr_wvalue);
        ms_entry.ex         = ms_ex;
        ms_entry.ecode      = ms_ecode;
        ms_entry.esubcode   = ms_esubcode;
        ms_entry.ertn       = ms_ertn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ws_valid <= 1'b0;
            ws_q     <= '0;
        end else begin
            if (accept)      ws_valid <= 1'b1;
            else if (retire) ws_valid <= 1'b0;
            if (accept)      ws_q     <= ms_entry;
        end
    end

    assign wdata = ws_q.csr_re ? WB_DATA_W'(csr_rvalue) : ws_q.result;

    assign rf_we       = retire & ws_q.gr_we & ~ws_q.ex;
    assign rf_waddr    = RADDR_W'(ws_q.dest);
    assign rf_wdata    = DATA_W'(wdata);
    assign csr_re      = ws_valid & ws_q.csr_re;
    assign csr_we      = retire & ws_q.csr_we & ~ws_q.ex;
    assign csr_num     = CSR_NUM_W'(ws_q.csr_num);
    assign csr_wmask   = DATA_W'(ws_q.csr_wmask);
    assign csr_wvalue  = DATA_W'(ws_q.csr_wvalue);
    assign wb_ex       = retire & ws_q.ex;
    assign ertn_flush  = retire & ws_q.ertn & ~ws_q.ex;
    assign wb_ecode    = ws_q.ecode;
    assign wb_esubcode = ws_q.esubcode;
    assign wb_pc       = DATA_W'(ws_q.pc);

    // Excepting instructions never reach the trace; ERTN does, with we=0.
    assign trace_push        = retire & ~ws_q.ex;
    assign trace_entry.pc    = ws_q.pc;
    assign trace_entry.we    = {4{rf_we}};
    assign trace_entry.waddr = ws_q.dest;
    assign trace_entry.wdata = wdata;

`ifdef WB_TRACE_FIFO_EN
    logic      trace_full;
    logic      trace_empty;
    wb_trace_t trace_head;

    wb_trace_fifo #(
        .WIDTH ($bits(wb_trace_t)),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (trace_push),
        .push_data (trace_entry),
        .pop       (trace_valid & trace_ready),
        .full      (trace_full),
        .empty     (trace_empty),
        .head      (trace_head)
    );

    // Stall on the registered full flag only, so trace_ready never reaches wb_allowin.
    assign ws_ready_go = ~trace_full;
    assign trace_valid = ~trace_empty;
    assign trace_view  = trace_valid ? trace_head : '0;
`else
    localparam int unused_trace_depth = TRACE_DEPTH;
    logic      unused_trace_ready;
    logic      trace_pulse;
    wb_trace_t trace_q;

    assign unused_trace_ready = trace_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            trace_pulse <= 1'b0;
            trace_q     <= '0;
        end else begin
            trace_pulse <= trace_push;
            if (trace_push) trace_q <= trace_entry;
        end
    end

    assign ws_ready_go = 1'b1;
    assign trace_valid = trace_pulse;
    assign trace_view  = trace_q;
`endif

    assign trace_pc    = DATA_W'(trace_view.pc);
    assign trace_we    = trace_view.we;
    assign trace_waddr = RADDR_W'(trace_view.waddr);
    assign trace_wdata = DATA_W'(trace_view.wdata);

endmodule

// File: tb/tb_wb_commit_stage.sv
// tb/tb_wb_commit_stage.sv - directed self-checking bench for wb_commit_stage
module tb_wb_commit_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ms_valid;
    logic [31:0] ms_pc, ms_result, ms_csr_wmask, ms_csr_wvalue;
    logic        ms_gr_we, ms_csr_re, ms_csr_we, ms_ex, ms_ertn;
    logic [4:0]  ms_dest;
    logic [13:0] ms_csr_num;
    logic [5:0]  ms_ecode;
    logic [8:0]  ms_esubcode;
    logic        wb_allowin, rf_we, csr_re, csr_we, wb_ex, ertn_flush;
    logic [4:0]  rf_waddr, trace_waddr;
    logic [31:0] rf_wdata, csr_wmask, csr_wvalue, csr_rvalue, wb_pc;
    logic [13:0] csr_num;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        trace_valid, trace_ready;
    logic [31:0] trace_pc, trace_wdata;
    logic [3:0]  trace_we;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_pc [8];
    logic [31:0] exp_dat[8];
    int drain_idx;

    wb_commit_stage #(.DATA_W(32), .RADDR_W(5), .CSR_NUM_W(14), .TRACE_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .ms_valid(ms_valid), .ms_pc(ms_pc), .ms_result(ms_result),
        .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we),
        .ms_csr_num(ms_csr_num), .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue),
        .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode), .ms_ertn(ms_ertn),
        .wb_allowin(wb_allowin), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
        .trace_we(trace_we), .trace_waddr(trace_waddr), .trace_wdata(trace_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic idle;
        ms_valid = 1'b0; ms_pc = '0; ms_result = '0; ms_gr_we = 1'b0; ms_dest = '0;
        ms_csr_re = 1'b0; ms_csr_we = 1'b0; ms_csr_num = '0; ms_csr_wmask = '0;
        ms_csr_wvalue = '0; ms_ex = 1'b0; ms_ecode = '0; ms_esubcode = '0; ms_ertn = 1'b0;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                         input logic gr_we);
        idle();
        ms_valid = 1'b1; ms_pc = pc; ms_result = res; ms_dest = dest; ms_gr_we = gr_we;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_allowin"}, wb_allowin, 1);
        chk({tag, "_rf_we"}, rf_we, 0);
        chk({tag, "_rf_waddr"}, rf_waddr, 0);
        chk({tag, "_rf_wdata"}, rf_wdata, 0);
        chk({tag, "_csr_re"}, csr_re, 0);
        chk({tag, "_csr_we"}, csr_we, 0);
        chk({tag, "_csr_num"}, csr_num, 0);
        chk({tag, "_csr_wmask"}, csr_wmask, 0);
        chk({tag, "_csr_wvalue"}, csr_wvalue, 0);
        chk({tag, "_wb_ex"}, wb_ex, 0);
        chk({tag, "_ertn"}, ertn_flush, 0);
        chk({tag, "_ecode"}, wb_ecode, 0);
        chk({tag, "_esub"}, wb_esubcode, 0);
        chk({tag, "_wb_pc"}, wb_pc, 0);
        chk({tag, "_tvalid"}, trace_valid, 0);
        chk({tag, "_tpc"}, trace_pc, 0);
        chk({tag, "_twe"}, trace_we, 0);
        chk({tag, "_twaddr"}, trace_waddr, 0);
        chk({tag, "_twdata"}, trace_wdata, 0);
    endtask

`ifdef WB_TRACE_FIFO_EN
    task automatic drain_check(input string tag);
        if (trace_valid && trace_ready) begin
            if (drain_idx < 8) begin
                chk({tag, "_pc"}, trace_pc, exp_pc[drain_idx]);
                chk({tag, "_wdata"}, trace_wdata, exp_dat[drain_idx]);
            end
            drain_idx++;
        end
    endtask
`endif

    initial begin
        rst = 1'b1; trace_ready = 1'b1; csr_rvalue = '0;
        idle();
        tick(); tick();
        rst = 1'b0;

        // Reset state, then a plain ADD
        offer(32'h1c000000, 32'h12345678, 5'd5, 1'b1);
        #1; check_reset_outputs("reset");
        tick();
        idle(); #1;
        chk("add_rf_we", rf_we, 1);
        chk("add_rf_waddr", rf_waddr, 5);
        chk("add_rf_wdata", rf_wdata, 32'h12345678);
        chk("add_trace_early", trace_valid, 0);
        tick();
        #1;
        chk("add_tvalid", trace_valid, 1);
        chk("add_tpc", trace_pc, 32'h1c000000);
        chk("add_twe", trace_we, 4'hf);
        chk("add_twaddr", trace_waddr, 5);
        chk("add_twdata", trace_wdata, 32'h12345678);
        tick();

        // CSR read+write: register file gets csr_rvalue
        offer(32'h1c000004, 32'h00001111, 5'd7, 1'b1);
        ms_csr_re = 1'b1; ms_csr_we = 1'b1; ms_csr_num = 14'h5;
        ms_csr_wmask = 32'h0000ffff; ms_csr_wvalue = 32'ha5a5a5a5;
        #1; chk("add_trace_once", trace_valid, 0);
        tick();
        idle(); csr_rvalue = 32'hdeadbeef; #1;
        chk("csr_re", csr_re, 1);
        chk("csr_we", csr_we, 1);
        chk("csr_num", csr_num, 14'h5);
        chk("csr_wmask", csr_wmask, 32'h0000ffff);
        chk("csr_wvalue", csr_wvalue, 32'ha5a5a5a5);
        chk("csr_rf_waddr", rf_waddr, 7);
        chk("csr_rf_wdata", rf_wdata, 32'hdeadbeef);
        tick();
        csr_rvalue = '0;
        offer(32'h1c000008, 32'h00000033, 5'd3, 1'b1);
        ms_csr_we = 1'b1; ms_ex = 1'b1; ms_ecode = 6'h0b;
        #1;
        chk("csr_tvalid", trace_valid, 1);
        chk("csr_tpc", trace_pc, 32'h1c000004);
        chk("csr_twaddr", trace_waddr, 7);
        chk("csr_twdata", trace_wdata, 32'hdeadbeef);
        chk("csr_re_clear", csr_re, 0);
        tick();

        // Syscall: flush pulse, no writes, following offer discarded
        offer(32'h1c00000c, 32'h00000044, 5'd9, 1'b1);
        #1;
        chk("sys_wb_ex", wb_ex, 1);
        chk("sys_ecode", wb_ecode, 6'h0b);
        chk("sys_esub", wb_esubcode, 0);
        chk("sys_wb_pc", wb_pc, 32'h1c000008);
        chk("sys_rf_we", rf_we, 0);
        chk("sys_csr_we", csr_we, 0);
        chk("sys_ertn", ertn_flush, 0);
        chk("sys_tvalid", trace_valid, 0);
        tick();
        idle(); #1;
        chk("sys_ex_pulse", wb_ex, 0);
        chk("sys_offer_dropped", rf_we, 0);
        chk("sys_no_trace", trace_valid, 0);
        tick();

        // ERTN: flush, no register write, trace entry with we=0
        offer(32'h1c000010, 32'h0, 5'd0, 1'b0);
        ms_ertn = 1'b1;
        #1; tick();
        idle(); #1;
        chk("ertn_flush", ertn_flush, 1);
        chk("ertn_wb_ex", wb_ex, 0);
        chk("ertn_rf_we", rf_we, 0);
        tick();
        #1;
        chk("ertn_tvalid", trace_valid, 1);
        chk("ertn_twe", trace_we, 0);
        chk("ertn_tpc", trace_pc, 32'h1c000010);
        tick();

`ifdef WB_TRACE_FIFO_EN
        // Backpressure: four entries fill the FIFO, the fifth is held in the stage
        for (int k = 0; k < 8; k++) begin
            exp_pc[k]  = 32'h1c000100 + 32'(4 * k);
            exp_dat[k] = 32'h000000a0 + 32'(k);
        end
        trace_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            offer(exp_pc[k], exp_dat[k], 5'(k + 1), 1'b1);
            #1; chk("bp_fill_allowin", wb_allowin, 1);
            tick();
        end
        offer(exp_pc[5], exp_dat[5], 5'd6, 1'b1);
        #1;
        chk("bp_full_allowin", wb_allowin, 0);
        chk("bp_full_rf_we", rf_we, 0);
        chk("bp_full_tvalid", trace_valid, 1);
        chk("bp_full_head", trace_pc, exp_pc[0]);
        tick();
        #1; chk("bp_hold_allowin", wb_allowin, 0);
        tick();
        drain_idx = 0;
        trace_ready = 1'b1; #1;
        chk("bp_no_comb_ready", wb_allowin, 0);
        drain_check("bp_drain");
        tick();
        #1;
        chk("bp_release_allowin", wb_allowin, 1);
        chk("bp_release_rf_we", rf_we, 1);
        chk("bp_release_waddr", rf_waddr, 5);
        drain_check("bp_drain");
        tick();
        idle(); #1;
        chk("bp_sixth_waddr", rf_waddr, 6);
        drain_check("bp_drain");
        tick();
        for (int i = 0; i < 8; i++) begin
            #1; drain_check("bp_drain");
            tick();
        end
        #1;
        chk("bp_drain_count", drain_idx, 6);
        chk("bp_drained_tvalid", trace_valid, 0);
        tick();

        // Push and pop together at occupancy 2 while the pointers wrap
        for (int k = 0; k < 8; k++) begin
            exp_pc[k]  = 32'h1c000200 + 32'(4 * k);
            exp_dat[k] = 32'h000000c0 + 32'(k);
        end
        trace_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            offer(exp_pc[k], exp_dat[k], 5'(k + 10), 1'b1);
            #1; tick();
        end
        drain_idx = 0;
        trace_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k + 3 < 8) offer(exp_pc[k + 3], exp_dat[k + 3], 5'(k + 13), 1'b1);
            else idle();
            #1;
            chk("wrap_allowin", wb_allowin, 1);
            chk("wrap_head_lag2", trace_pc, exp_pc[k]);
            drain_check("wrap_drain");
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            #1; drain_check("wrap_drain");
            tick();
        end
        #1;
        chk("wrap_drain_count", drain_idx, 8);
        chk("wrap_drained_tvalid", trace_valid, 0);
        tick();
`else
        // Without a FIFO trace_ready is ignored and trace_valid pulses once per retire
        trace_ready = 1'b0;
        offer(32'h1c000100, 32'h000000a0, 5'd1, 1'b1);
        #1; tick();
        offer(32'h1c000104, 32'h000000a1, 5'd2, 1'b1);
        #1;
        chk("nf_allowin1", wb_allowin, 1);
        chk("nf_rf_we1", rf_we, 1);
        tick();
        offer(32'h1c000108, 32'h000000a2, 5'd3, 1'b1);
        #1;
        chk("nf_allowin2", wb_allowin, 1);
        chk("nf_tvalid1", trace_valid, 1);
        chk("nf_tpc1", trace_pc, 32'h1c000100);
        tick();
        idle(); #1;
        chk("nf_tvalid2", trace_valid, 1);
        chk("nf_tpc2", trace_pc, 32'h1c000104);
        chk("nf_waddr3", rf_waddr, 3);
        tick();
        #1;
        chk("nf_tvalid3", trace_valid, 1);
        chk("nf_twdata3", trace_wdata, 32'h000000a2);
        tick();
        #1;
        chk("nf_pulse_end", trace_valid, 0);
        chk("nf_tpc_held", trace_pc, 32'h1c000108);
        tick();
`endif

        // Reset with queued trace entries and an instruction in the stage
        trace_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            offer(32'h1c000300 + 32'(4 * k), 32'h000000e0 + 32'(k), 5'(k + 20), 1'b1);
            #1; tick();
        end
        idle(); #1;
        chk("mid_rf_we", rf_we, 1);
        chk("mid_tvalid", trace_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check_reset_outputs("midrst");
        tick();

        trace_ready = 1'b1;
        offer(32'h1c000400, 32'h00000077, 5'd2, 1'b1);
        #1; tick();
        idle(); #1;
        chk("post_rf_we", rf_we, 1);
        tick();
        #1;
        chk("post_tvalid", trace_valid, 1);
        chk("post_tpc", trace_pc, 32'h1c000400);
        tick();
        #1;
        chk("post_empty", trace_valid, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
